// File: rtl/seq_det_ctrl_if.sv
// seq_det_ctrl_if: word-side handshake and detector-side serial link of the
// sequencing controller. The master modport is the environment (producer
// plus detector); the slave modport is the controller itself.
interface seq_det_ctrl_if #(
  parameter int W  = 8,
  parameter int CW = 4
);
  logic          start;
  logic [W-1:0]  data;
  logic          busy;
  logic          done;
  logic [CW-1:0] match_cnt;
  logic          det_a;
  logic          det_rst;
  logic          det_out;

  modport master (
    output start, data, det_out,
    input  busy, done, match_cnt, det_a, det_rst
  );

  modport slave (
    input  start, data, det_out,
    output busy, done, match_cnt, det_a, det_rst
  );
endinterface

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: accepts a parallel word on start, clears the serial Moore
// detector for one cycle, shifts the word into it one bit per clock, then
// counts the detector's sampled match outputs into a saturating counter and
// strobes done for one cycle.
// Build option: define SEQ_DET_CTRL_LSB_FIRST_EN to serialise LSB first
// (default is MSB first). Sampling, latency and counting are unchanged.
module seq_det_ctrl #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_det_ctrl_if.slave    bus
);

  localparam int            KW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [KW-1:0] K_LAST  = KW'(W - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] match_q, match_d;
  logic          det_a_q, det_a_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          clr_q, clr_d;
  logic          sample;

  // Bit of the captured word presented to the detector at serial position idx.
  function automatic logic sel_bit(input logic [W-1:0] word, input logic [KW-1:0] idx);
`ifdef SEQ_DET_CTRL_LSB_FIRST_EN
    return word[idx];
`else
    return word[K_LAST - idx];
`endif
  endfunction

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + CW'(1);
  endfunction

  // Next-state, shift, counter and registered-output logic.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    sr_d    = sr_q;
    match_d = match_q;
    det_a_d = 1'b0;

    // The detector output lags det_a by one cycle, so the k = 0 slot still
    // shows the cleared state; the DRAIN slot picks up the last bit's result.
    sample = ((state_q == S_SHIFT) && (k_q != '0)) || (state_q == S_DRAIN);
    if (sample && bus.det_out) begin
      match_d = sat_inc(match_q);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_CLR;
          sr_d    = bus.data;
          match_d = '0;
          k_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        state_d = S_SHIFT;
        k_d     = '0;
        det_a_d = sel_bit(sr_q, '0);
      end
      S_SHIFT: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d     = k_q + 1'b1;
          det_a_d = sel_bit(sr_q, k_q + 1'b1);
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_CLR) || (state_d == S_SHIFT) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
    clr_d  = (state_d == S_CLR);
  end

  // Control state and registered outputs; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      match_q <= '0;
      det_a_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      match_q <= match_d;
      det_a_q <= det_a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      clr_q   <= clr_d;
    end
  end

  // Captured word; only read while a run is active, so it needs no reset.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.match_cnt = match_q;
  assign bus.det_a     = det_a_q;
  // The detector is also held in reset for as long as rst is asserted.
  assign bus.det_rst   = rst | clr_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: scoreboard bench. Two controllers (CW = 4 and CW = 2)
// receive identical stimulus; a run-phase reference model queues the
// expected per-cycle outputs and final counts, and a monitor compares.
module tb_seq_det_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst;

  seq_det_ctrl_if #(.W(W), .CW(4)) ifa ();
  seq_det_ctrl_if #(.W(W), .CW(2)) ifb ();

  seq_det_ctrl #(.W(W), .CW(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  seq_det_ctrl #(.W(W), .CW(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SEQ_DET_CTRL_LSB_FIRST_EN
  localparam logic [7:0] EXP_SER = 8'h6D;
`else
  localparam logic [7:0] EXP_SER = 8'hB6;
`endif

  typedef struct {
    bit busy;
    bit done;
    bit det_a;
    bit det_rst;
    int cnt;
  } exp_t;

  exp_t cyc_q[$];
  int   done_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model: phase = cycles since the accepting edge (0 = idle).
  int           phase = 0;
  int           cnt   = 0;
  logic [W-1:0] word  = '0;

  function automatic int sat(input int c, input int m);
    return (c > m) ? m : c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit s, input logic [W-1:0] d, input bit dout);
    exp_t e;
    int   k;
    if (r) begin
      phase = 0;
      cnt   = 0;
    end else if ((phase == 0 || phase == W + 3) && s) begin
      phase = 1;
      word  = d;
      cnt   = 0;
    end else if (phase >= 1 && phase <= W + 2) begin
      if (phase >= 3 && dout) cnt++;
      phase++;
      if (phase == W + 3) done_q.push_back(cnt);
    end else begin
      phase = 0;
    end
    e.busy    = (phase >= 1 && phase <= W + 2);
    e.done    = (phase == W + 3);
    e.det_rst = r || (phase == 1);
    e.det_a   = 1'b0;
    if (phase >= 2 && phase <= W + 1) begin
      k = phase - 2;
`ifdef SEQ_DET_CTRL_LSB_FIRST_EN
      e.det_a = word[k];
`else
      e.det_a = word[W - 1 - k];
`endif
    end
    e.cnt = cnt;
    cyc_q.push_back(e);
  endtask

  // One clock: drive inputs on the falling edge, advance the model on the rising edge.
  task automatic cyc(input bit r, input bit s, input logic [W-1:0] d, input bit dout);
    @(negedge clk);
    rst         = r;
    ifa.start   = s;
    ifb.start   = s;
    ifa.data    = d;
    ifb.data    = d;
    ifa.det_out = dout;
    ifb.det_out = dout;
    @(posedge clk);
    model_step(r, s, d, dout);
  endtask

  // Monitor: per-cycle comparison plus final-count check on every done strobe.
  exp_t me;
  int   mcnt;
  always @(posedge clk) begin
    #1;
    if (cyc_q.size() > 0) begin
      me = cyc_q.pop_front();
      chk("busy_a",    ifa.busy,      me.busy);
      chk("done_a",    ifa.done,      me.done);
      chk("det_a_a",   ifa.det_a,     me.det_a);
      chk("det_rst_a", ifa.det_rst,   me.det_rst);
      chk("cnt_a",     ifa.match_cnt, sat(me.cnt, 15));
      chk("busy_b",    ifb.busy,      me.busy);
      chk("done_b",    ifb.done,      me.done);
      chk("det_a_b",   ifb.det_a,     me.det_a);
      chk("cnt_b",     ifb.match_cnt, sat(me.cnt, 3));
    end
    if (ifa.done === 1'b1) begin
      if (done_q.size() == 0) begin
        chk("done_unexpected", ifa.done, 0);
      end else begin
        mcnt = done_q.pop_front();
        chk("final_cnt_a", ifa.match_cnt, sat(mcnt, 15));
        chk("final_cnt_b", ifb.match_cnt, sat(mcnt, 3));
      end
    end
  end

  logic [7:0] ser;

  initial begin
    rst         = 1'b1;
    ifa.start   = 1'b0;
    ifb.start   = 1'b0;
    ifa.data    = '0;
    ifb.data    = '0;
    ifa.det_out = 1'b0;
    ifb.det_out = 1'b0;

    // Reset then idle.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    #1;
    chk("rst_det_rst", ifa.det_rst, 1);
    chk("rst_cnt", ifa.match_cnt, 0);
    repeat (3) cyc(0, 0, 0, 0);
    #1;
    chk("idle_busy", ifa.busy, 0);
    chk("idle_det_rst", ifa.det_rst, 0);

    // Serialise 8'hB6, count slots 2/5/8 only, ignore a start during SHIFT.
    cyc(0, 1, 8'hB6, 1);
    #1;
    chk("clr_det_rst", ifa.det_rst, 1);
    ser = '0;
    for (int p = 1; p <= W + 2; p++) begin
      cyc(0, (p == 5), (p == 5) ? 8'hFF : 8'h00,
          (p == 2 || p == 4 || p == 7 || p == 10));
      #1;
      if (p + 1 >= 2 && p + 1 <= W + 1) ser = {ser[6:0], ifa.det_a};
    end
    chk("ser_word", ser, EXP_SER);
    chk("slot_done", ifa.done, 1);
    chk("slot_cnt", ifa.match_cnt, 3);

    // Back-to-back start during DONE, then a saturating run (det_out stuck high).
    cyc(0, 1, 8'h0F, 1);
    #1;
    chk("b2b_busy", ifa.busy, 1);
    chk("b2b_cnt", ifa.match_cnt, 0);
    chk("b2b_det_rst", ifa.det_rst, 1);
    for (int p = 1; p <= W + 2; p++) cyc(0, 0, 0, 1);
    #1;
    chk("sat_done", ifb.done, 1);
    chk("sat_cnt_b", ifb.match_cnt, 3);
    chk("sat_cnt_a", ifa.match_cnt, 8);

    // Mid-run reset at SHIFT k = 4, then a normal run.
    cyc(0, 0, 0, 0);
    cyc(0, 1, 8'h5A, 1);
    for (int p = 1; p <= 5; p++) cyc(0, 0, 0, 1);
    cyc(1, 0, 0, 1);
    #1;
    chk("abort_busy", ifa.busy, 0);
    chk("abort_cnt", ifa.match_cnt, 0);
    chk("abort_det_rst", ifa.det_rst, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, W'($urandom), 0);
    for (int p = 1; p <= W + 2; p++) cyc(0, 0, 0, 1'($urandom_range(0, 1)));
    #1;
    chk("rerun_done", ifa.done, 1);

    // Randomised traffic including occasional resets and back-to-back starts.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
          W'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (W + 5) cyc(0, 0, 0, 0);
    #2;
    chk("cyc_q_drained", cyc_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
